// File: rtl/beat_slope_detector.sv
// Slope-history peak/trough detector for the heart-rate pipeline.
// It takes one filtered sample per sample_valid strobe. A DEPTH-bit history
// records whether each sample fell relative to the one before it. A peak is
// declared when the older half of the history is mostly rising and the newer
// half is mostly falling. A refractory window blocks repeat detections.
// The block also counts detections and reports the spacing between beats,
// measured in accepted samples.
module beat_slope_detector #(
    parameter int W         = 10,
    parameter int DEPTH     = 128,
    parameter int LEFT_MAX  = 40,
    parameter int RIGHT_MIN = 38,
    parameter int REFRACT   = 128,
    parameter int IVL_W     = 16,
    parameter int CNT_W     = 8,
    parameter int TROUGH    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [W-1:0]     sample,
    output logic             peak,
    output logic             interval_valid,
    output logic [IVL_W-1:0] interval,
    output logic [CNT_W-1:0] peak_count,
    output logic             armed
);

    localparam int HALF   = DEPTH / 2;
    localparam int SW     = $clog2(HALF) + 1;
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int REFR_W = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);

    localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] FILL_ONE    = FILL_W'(1'b1);
    localparam logic [REFR_W-1:0] REFR_LOAD   = REFR_W'(REFRACT);
    localparam logic [REFR_W-1:0] REFR_ONE    = REFR_W'(1'b1);
    localparam logic [IVL_W-1:0]  IVL_ONE     = IVL_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);
    localparam logic [31:0]       LEFT_MAX_C  = 32'(LEFT_MAX);
    localparam logic [31:0]       RIGHT_MIN_C = 32'(RIGHT_MIN);

    // State registers
    logic [W-1:0]      prev_r;
    logic [DEPTH-1:0]  hist_r;
    logic [SW-1:0]     lsum_r;
    logic [SW-1:0]     rsum_r;
    logic [FILL_W-1:0] fill_r;
    logic              first_seen_r;
    logic              have_peak_r;
    logic [REFR_W-1:0] refr_r;
    logic [IVL_W-1:0]  ivl_cnt_r;

    // Output registers
    logic              peak_r;
    logic              interval_valid_r;
    logic [IVL_W-1:0]  interval_r;
    logic [CNT_W-1:0]  peak_count_r;
    logic              armed_r;

    // Next-state helpers
    logic              update_s;
    logic              slope_s;
    logic [DEPTH-1:0]  hist_next_s;
    logic [SW-1:0]     lsum_next_s;
    logic [SW-1:0]     rsum_next_s;
    logic [FILL_W-1:0] fill_next_s;
    logic              detect_s;
    logic [IVL_W-1:0]  ivl_inc_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [REFR_W-1:0] refr_dec_s;

    // Slope bit, history/sum updates, and the detect decision for the current sample
    always_comb begin
        // Only samples after the first one produce a slope bit.
        update_s = sample_valid & first_seen_r;

        if (TROUGH != 0) begin
            slope_s = (sample > prev_r);
        end else begin
            slope_s = (sample < prev_r);
        end

        hist_next_s = {hist_r[DEPTH-2:0], slope_s};
        // The bit leaving the newer half enters the older half. The oldest bit is discarded.
        rsum_next_s = rsum_r + SW'(slope_s) - SW'(hist_r[HALF-1]);
        lsum_next_s = lsum_r + SW'(hist_r[HALF-1]) - SW'(hist_r[DEPTH-1]);

        if (fill_r == FILL_FULL) begin
            fill_next_s = fill_r;
        end else begin
            fill_next_s = fill_r + FILL_ONE;
        end

        if (&ivl_cnt_r) begin
            ivl_inc_s = ivl_cnt_r;
        end else begin
            ivl_inc_s = ivl_cnt_r + IVL_ONE;
        end

        if (&peak_count_r) begin
            cnt_inc_s = peak_count_r;
        end else begin
            cnt_inc_s = peak_count_r + CNT_ONE;
        end

        if (refr_r != {REFR_W{1'b0}}) begin
            refr_dec_s = refr_r - REFR_ONE;
        end else begin
            refr_dec_s = refr_r;
        end

        detect_s = update_s
                 && (fill_next_s == FILL_FULL)
                 && (32'(lsum_next_s) <= LEFT_MAX_C)
                 && (32'(rsum_next_s) >= RIGHT_MIN_C)
                 && (refr_r == {REFR_W{1'b0}});
    end

    // Sample-accept state machine: history, refractory window, interval counter and outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r           <= {W{1'b0}};
            hist_r           <= {DEPTH{1'b0}};
            lsum_r           <= {SW{1'b0}};
            rsum_r           <= {SW{1'b0}};
            fill_r           <= {FILL_W{1'b0}};
            first_seen_r     <= 1'b0;
            have_peak_r      <= 1'b0;
            refr_r           <= {REFR_W{1'b0}};
            ivl_cnt_r        <= {IVL_W{1'b0}};
            peak_r           <= 1'b0;
            interval_valid_r <= 1'b0;
            interval_r       <= {IVL_W{1'b0}};
            peak_count_r     <= {CNT_W{1'b0}};
            armed_r          <= 1'b0;
        end else if (clear) begin
            // A sample presented together with clear is discarded.
            prev_r           <= {W{1'b0}};
            hist_r           <= {DEPTH{1'b0}};
            lsum_r           <= {SW{1'b0}};
            rsum_r           <= {SW{1'b0}};
            fill_r           <= {FILL_W{1'b0}};
            first_seen_r     <= 1'b0;
            have_peak_r      <= 1'b0;
            refr_r           <= {REFR_W{1'b0}};
            ivl_cnt_r        <= {IVL_W{1'b0}};
            peak_r           <= 1'b0;
            interval_valid_r <= 1'b0;
            interval_r       <= {IVL_W{1'b0}};
            peak_count_r     <= {CNT_W{1'b0}};
            armed_r          <= 1'b0;
        end else begin
            peak_r           <= detect_s;
            interval_valid_r <= detect_s & have_peak_r;
            if (sample_valid) begin
                prev_r <= sample;
                if (!first_seen_r) begin
                    // The first sample only provides the reference for the next slope.
                    first_seen_r <= 1'b1;
                end else begin
                    hist_r  <= hist_next_s;
                    lsum_r  <= lsum_next_s;
                    rsum_r  <= rsum_next_s;
                    fill_r  <= fill_next_s;
                    armed_r <= (fill_next_s == FILL_FULL);
                    if (detect_s) begin
                        peak_count_r <= cnt_inc_s;
                        refr_r       <= REFR_LOAD;
                        if (have_peak_r) begin
                            interval_r <= ivl_inc_s;
                        end
                        have_peak_r  <= 1'b1;
                        ivl_cnt_r    <= {IVL_W{1'b0}};
                    end else begin
                        refr_r <= refr_dec_s;
                        if (have_peak_r) begin
                            ivl_cnt_r <= ivl_inc_s;
                        end
                    end
                end
            end
        end
    end

    assign peak           = peak_r;
    assign interval_valid = interval_valid_r;
    assign interval       = interval_r;
    assign peak_count     = peak_count_r;
    assign armed          = armed_r;

endmodule

// File: tb/tb_beat_slope_detector.sv
// Bench for beat_slope_detector. A peak-mode and a trough-mode instance share
// the same stimulus. Both are compared every cycle against a window-based
// reference model that recomputes the slope counts from the accepted-sample
// history.
module tb_beat_slope_detector;

    localparam int W     = 10;
    localparam int DEPTH = 8;
    localparam int LM    = 0;
    localparam int RM    = 4;
    localparam int RF    = 6;
    localparam int IVL_W = 5;
    localparam int CNT_W = 3;
    localparam int IMAX  = (1 << IVL_W) - 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear;
    logic             sample_valid;
    logic [W-1:0]     sample;

    logic             peak_a, ivv_a, armed_a;
    logic [IVL_W-1:0] ivl_a;
    logic [CNT_W-1:0] cnt_a;
    logic             peak_b, ivv_b, armed_b;
    logic [IVL_W-1:0] ivl_b;
    logic [CNT_W-1:0] cnt_b;

    always #5 clk = ~clk;

    beat_slope_detector #(.W(W), .DEPTH(DEPTH), .LEFT_MAX(LM), .RIGHT_MIN(RM),
        .REFRACT(RF), .IVL_W(IVL_W), .CNT_W(CNT_W), .TROUGH(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear), .sample_valid(sample_valid),
        .sample(sample), .peak(peak_a), .interval_valid(ivv_a), .interval(ivl_a),
        .peak_count(cnt_a), .armed(armed_a));

    beat_slope_detector #(.W(W), .DEPTH(DEPTH), .LEFT_MAX(LM), .RIGHT_MIN(RM),
        .REFRACT(RF), .IVL_W(IVL_W), .CNT_W(CNT_W), .TROUGH(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .sample_valid(sample_valid),
        .sample(sample), .peak(peak_b), .interval_valid(ivv_b), .interval(ivl_b),
        .peak_count(cnt_b), .armed(armed_b));

    int total = 0;
    int bad   = 0;

    // Reference model state. Index 0 is peak mode and index 1 is trough mode.
    int q[$];
    int n_acc;
    int e_armed;
    int havep[2], last[2], e_cnt[2], e_ivl[2], e_peak[2], e_ivv[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        n_acc   = 0;
        e_armed = 0;
        for (int t = 0; t < 2; t++) begin
            havep[t] = 0; last[t] = 0; e_cnt[t] = 0; e_ivl[t] = 0;
            e_peak[t] = 0; e_ivv[t] = 0;
        end
    endtask

    task automatic model_sample(input int s);
        int l, r, fall;
        q.push_back(s);
        if (q.size() > DEPTH + 1) void'(q.pop_front());
        n_acc++;
        e_armed = (q.size() == DEPTH + 1) ? 1 : 0;
        for (int t = 0; t < 2; t++) begin
            if (q.size() == DEPTH + 1) begin
                l = 0; r = 0;
                for (int i = 1; i <= DEPTH; i++) begin
                    fall = (t == 0) ? int'(q[i] < q[i-1]) : int'(q[i] > q[i-1]);
                    if (i <= DEPTH / 2) l += fall; else r += fall;
                end
                if (l <= LM && r >= RM && (havep[t] == 0 || n_acc - last[t] > RF)) begin
                    e_peak[t] = 1;
                    e_cnt[t]  = (e_cnt[t] < CMAX) ? e_cnt[t] + 1 : CMAX;
                    if (havep[t] != 0) begin
                        e_ivv[t] = 1;
                        e_ivl[t] = (n_acc - last[t] > IMAX) ? IMAX : n_acc - last[t];
                    end
                    havep[t] = 1;
                    last[t]  = n_acc;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("peak_a",  peak_a,  e_peak[0]);
        chk("ivv_a",   ivv_a,   e_ivv[0]);
        chk("ivl_a",   ivl_a,   e_ivl[0]);
        chk("cnt_a",   cnt_a,   e_cnt[0]);
        chk("armed_a", armed_a, e_armed);
        chk("peak_b",  peak_b,  e_peak[1]);
        chk("ivv_b",   ivv_b,   e_ivv[1]);
        chk("ivl_b",   ivl_b,   e_ivl[1]);
        chk("cnt_b",   cnt_b,   e_cnt[1]);
        chk("armed_b", armed_b, e_armed);
    endtask

    task automatic step(input bit v, input int s, input bit c);
        sample_valid = v;
        sample       = W'(s);
        clear        = c;
        @(posedge clk);
        #1;
        e_peak[0] = 0; e_peak[1] = 0; e_ivv[0] = 0; e_ivv[1] = 0;
        if (c) model_reset();
        else if (v) model_sample(s);
        check_all();
    endtask

    int tri_v, cur, dir, amt;
    int up_seq[9]   = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
    int down_seq[9] = '{4, 3, 2, 1, 0, 1, 2, 3, 4};

    initial begin
        reset_n = 1'b0; clear = 1'b0; sample_valid = 1'b0; sample = {W{1'b0}};
        model_reset();

        // Reset held while sample_valid toggles
        for (int i = 0; i < 6; i++) begin
            sample_valid = i[0];
            sample       = W'($urandom_range(0, 1023));
            @(posedge clk);
            #1;
            check_all();
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0);

        // Single peak on the 9th sample
        foreach (up_seq[i]) step(1'b1, up_seq[i], 1'b0);
        chk("single_peak", peak_a, 1);
        chk("single_armed", armed_a, 1);
        chk("single_ivv", ivv_a, 0);

        // Flat input produces no peak
        for (int i = 0; i < 100; i++) step(1'b1, 5, 1'b0);
        chk("flat_count", cnt_a, 1);

        // Periodic triangle with random gaps in sample_valid
        for (int k = 0; k < 16 * 12; k++) begin
            while ($urandom_range(0, 3) == 0) step(1'b0, 0, 1'b0);
            tri_v = (k % 16 < 8) ? k % 16 : 16 - k % 16;
            step(1'b1, tri_v, 1'b0);
        end
        chk("tri_interval", ivl_a, 16);
        chk("tri_count_sat", cnt_a, CMAX);

        // Clear together with a valid sample; the next peak needs 9 fresh samples
        step(1'b1, 7, 1'b1);
        chk("clear_count", cnt_a, 0);
        chk("clear_armed", armed_a, 0);
        for (int i = 0; i < 8; i++) step(1'b1, up_seq[i], 1'b0);
        chk("clear_no_early_peak", peak_a, 0);
        step(1'b1, up_seq[8], 1'b0);
        chk("clear_peak9", peak_a, 1);

        // Long flat gap, so the next interval saturates
        for (int i = 0; i < 40; i++) step(1'b1, 0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0);
        for (int i = 7; i >= 0; i--) step(1'b1, i, 1'b0);
        chk("ivl_sat", ivl_a, IMAX);

        // Trough mode
        step(1'b0, 0, 1'b1);
        foreach (down_seq[i]) step(1'b1, down_seq[i], 1'b0);
        chk("trough_peak", peak_b, 1);
        chk("trough_a_quiet", peak_a, 0);

        // Randomized random-walk stimulus with occasional clears
        cur = 512; dir = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) dir = -dir;
            amt = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20));
            cur = cur + dir * amt;
            if (cur < 0) cur = 0;
            if (cur > 1023) cur = 1023;
            step($urandom_range(0, 3) != 0, cur, $urandom_range(0, 299) == 0);
        end

        // Reset mid-stream
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            model_reset();
            check_all();
        end
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b1, up_seq[i % 9], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beat_slope_detector.md
# beat_slope_detector

Parametrised slope-history peak detector for the heart-rate pipeline. It sits between the FIR filter output and the rate calculation. It takes one filtered sample per `sample_valid` strobe rather than deriving timing from an SPI bit counter. It detects peaks (or troughs) from a DEPTH-bit rising/falling history, enforces a refractory period, counts detections, and reports the sample interval between successive beats.

## Interface
Parameters:
- `W`, 10: sample width (unsigned).
- `DEPTH`, 128: slope-history length; even, ≥4.
- `LEFT_MAX`, 40: maximum count of falling bits allowed in the older half.
- `RIGHT_MIN`, 38: minimum count of falling bits required in the newer half.
- `REFRACT`, 128: number of accepted samples after a detection during which detection is blocked.
- `IVL_W`, 16: interval width.
- `CNT_W`, 8: detection-count width.
- `TROUGH`, 0: 1 inverts slope sense, so the block detects troughs.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear to the reset state.
- `sample_valid` in 1: accept `sample` this cycle.
- `sample` in W: filtered sample.
- `peak` out 1: one-clock detection pulse.
- `interval_valid` out 1: one-clock pulse; `interval` is updated.
- `interval` out IVL_W: accepted samples between the last two detections.
- `peak_count` out CNT_W: detections since reset or clear; saturating.
- `armed` out 1: history is full, so detection is enabled.

## Operation
- **State:** `prev` (W), `hist` (DEPTH bits, bit 0 newest), `lsum`/`rsum` (clog2(DEPTH/2)+1 bits each), `fill` (0..DEPTH), `first_seen`, `have_peak`, `refr` (0..REFRACT), `ivl_cnt` (IVL_W).
- **First accepted sample after reset/clear:** loads `prev` only. No slope bit is generated; `first_seen` is set.
- **Each later accepted sample:**
  - Slope bit: d = (sample < prev) when TROUGH=0, or d = (sample > prev) when TROUGH=1. Comparison is unsigned; equal samples give d=0.
  - `hist` <= {hist[DEPTH-2:0], d}.
  - rsum' = rsum + d − hist[DEPTH/2−1].
  - lsum' = lsum + hist[DEPTH/2−1] − hist[DEPTH−1].
  - `fill` increments and saturates at DEPTH; `prev` <= sample.
- **Detect condition**, evaluated on post-update values: fill'==DEPTH, lsum'≤LEFT_MAX, rsum'≥RIGHT_MIN, and refr==0.
- **On detect:**
  - `peak` pulses.
  - `peak_count` increments, saturating at 2^CNT_W−1.
  - `refr` <= REFRACT.
  - If `have_peak`: `interval` <= sat(ivl_cnt+1) and `interval_valid` pulses.
  - `have_peak` <= 1; `ivl_cnt` <= 0.
- **On an accepted sample with no detect:**
  - `refr` decrements if nonzero.
  - If `have_peak`, `ivl_cnt` increments, saturating at 2^IVL_W−1.
- `interval` therefore equals j−i for detections on accepted samples i and j, saturating at 2^IVL_W−1.
- **No `sample_valid`:** all state holds and the pulses are low.
- **`clear`:** priority over `sample_valid`; a sample presented in the same cycle is discarded. All state returns to reset values.

## Timing
- **Reset values:** all outputs and state are 0; `hist` is all zeros.
- **Latency:** `peak`, `interval_valid`, `interval`, `peak_count`, `armed` are registered and update on the clock edge that samples `sample_valid`. They are visible 1 cycle later.
- **Throughput:** `sample_valid` may be high every cycle.
- **Pulse width:** pulses are exactly one clock wide; back-to-back pulses are impossible when REFRACT≥1.
- **Earliest detection:** on accepted sample DEPTH+1 after reset/clear, since `armed` rises there.
- **Reset mid-stream:** history is lost; re-arming needs DEPTH+1 more samples.

## Test plan
- **Reset:** hold `reset_n`=0 and toggle `sample_valid` -> all outputs 0. After release with no samples, outputs remain 0.
- **Single peak** (W=10, DEPTH=8, LEFT_MAX=0, RIGHT_MIN=4, REFRACT=6): feed 0,1,2,3,4,3,2,1,0 -> `armed` and `peak` go high one clock after sample 0 (the 9th); `peak_count`=1; `interval_valid` stays 0. Constant 5s for 100 samples -> no `peak`.
- **Periodic interval** (same config): continuous triangle, 8 up/8 down, period 16 -> `peak` every 16 accepted samples; `interval_valid` from the second peak with `interval`=16. Gaps in `sample_valid` do not change `interval`.
- **Refractory:** REFRACT=20, same triangle -> peaks every 32 samples, `interval`=32.
- **Trough mode:** TROUGH=1, sequence 4,3,2,1,0,1,2,3,4 -> `peak` after the 9th sample.
- **Clear and saturation:**
  - `clear` together with `sample_valid` mid-stream -> outputs 0 and that sample dropped; next peak needs 9 samples.
  - CNT_W=2 with 5 peaks -> `peak_count` stays 3.
  - IVL_W=4 with period 32 -> `interval`=15.
